// File: rtl/dds_pkg.sv
// Shared DDS definitions: FIFO select codes and the loader FSM state type.
package dds_pkg;

  localparam logic [1:0] THETAS = 2'd0;
  localparam logic [1:0] DELTAS = 2'd1;
  localparam logic [1:0] AMPLS  = 2'd2;
  localparam logic [1:0] NONE   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LD_THETA = 3'd1,
    ST_LD_DELTA = 3'd2,
    ST_LD_AMPL  = 3'd3,
    ST_START    = 3'd4
  } dds_ld_state_t;

endpackage

// File: rtl/dds_loader_if.sv
// Host configuration write bus of the DDS loader.
interface dds_loader_if #(
  parameter int SIG_WIDTH = 16,
  parameter int N_CH      = 8
);
  localparam int CH_W = $clog2(N_CH);

  logic                 i_cfg_valid;
  logic                 o_cfg_ready;
  logic [1:0]           i_cfg_sel;
  logic [CH_W-1:0]      i_cfg_ch;
  logic [SIG_WIDTH-1:0] i_cfg_data;
  logic                 o_cfg_err;

  modport master (
    output i_cfg_valid, i_cfg_sel, i_cfg_ch, i_cfg_data,
    input  o_cfg_ready, o_cfg_err
  );

  modport slave (
    input  i_cfg_valid, i_cfg_sel, i_cfg_ch, i_cfg_data,
    output o_cfg_ready, o_cfg_err
  );
endinterface

// File: rtl/dds_cfg_regfile.sv
// 3 x N_CH shadow parameter store: one write port, one combinational read port.
module dds_cfg_regfile
  import dds_pkg::*;
#(
  parameter int SIG_WIDTH = 16,
  parameter int N_CH      = 8,
  localparam int CH_W     = $clog2(N_CH)
) (
  input  logic                 clk,
  input  logic                 i_rst,
  input  logic                 i_we,
  input  logic [1:0]           i_wr_sel,
  input  logic [CH_W-1:0]      i_wr_ch,
  input  logic [SIG_WIDTH-1:0] i_wr_data,
  input  logic [1:0]           i_rd_sel,
  input  logic [CH_W-1:0]      i_rd_ch,
  output logic [SIG_WIDTH-1:0] o_rd_data
);

  logic [SIG_WIDTH-1:0] mem [0:2][0:N_CH-1];

  always_ff @(posedge clk) begin
    if (i_rst) begin
      for (int unsigned b = 0; b < 3; b++)
        for (int unsigned c = 0; c < N_CH; c++)
          mem[b][c] <= '0;
    end else if (i_we && i_wr_sel != NONE) begin
      mem[i_wr_sel][i_wr_ch] <= i_wr_data;
    end
  end

  always_comb begin
    o_rd_data = '0;
    if (i_rd_sel != NONE)
      o_rd_data = mem[i_rd_sel][i_rd_ch];
  end

endmodule

// File: rtl/dds_loader.sv
// Shadows DDS channel parameters and streams them into the DDS FIFOs on commit.
module dds_loader
  import dds_pkg::*;
#(
  parameter int SIG_WIDTH = 16,
  parameter int N_CH      = 8,
  localparam int CH_W     = $clog2(N_CH)
) (
  input  logic                 clk,
  input  logic                 i_rst,
  dds_loader_if.slave          cfg,
  input  logic                 i_commit,
  output logic                 o_busy,
  output logic                 o_dds_wr,
  output logic [1:0]           o_dds_addrs,
  output logic [SIG_WIDTH-1:0] o_dds_fifo_data,
  output logic                 o_dds_start
);

  dds_ld_state_t        state;
  logic [CH_W-1:0]      cnt;
  logic                 pending;
  logic                 cfg_err;
  logic                 accept;
  logic [1:0]           ld_addr;
  logic                 in_ld;
  logic [SIG_WIDTH-1:0] rd_data;

  assign cfg.o_cfg_ready = !o_busy;
  assign cfg.o_cfg_err   = cfg_err;
  assign accept          = cfg.i_cfg_valid && !o_busy;

  dds_cfg_regfile #(
    .SIG_WIDTH (SIG_WIDTH),
    .N_CH      (N_CH)
  ) u_regfile (
    .clk       (clk),
    .i_rst     (i_rst),
    .i_we      (accept),
    .i_wr_sel  (cfg.i_cfg_sel),
    .i_wr_ch   (cfg.i_cfg_ch),
    .i_wr_data (cfg.i_cfg_data),
    .i_rd_sel  (ld_addr),
    .i_rd_ch   (cnt),
    .o_rd_data (rd_data)
  );

  always_comb begin
    ld_addr = NONE;
    case (state)
      ST_LD_THETA: ld_addr = THETAS;
      ST_LD_DELTA: ld_addr = DELTAS;
      ST_LD_AMPL:  ld_addr = AMPLS;
      default:     ld_addr = NONE;
    endcase
    in_ld = (ld_addr != NONE);
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      pending         <= 1'b0;
      cfg_err         <= 1'b0;
      o_busy          <= 1'b0;
      o_dds_wr        <= 1'b0;
      o_dds_addrs     <= NONE;
      o_dds_fifo_data <= '0;
      o_dds_start     <= 1'b0;
    end else begin
      cfg_err         <= accept && (cfg.i_cfg_sel == NONE);
      o_busy          <= (state != ST_IDLE);
      o_dds_wr        <= in_ld;
      o_dds_addrs     <= ld_addr;
      o_dds_fifo_data <= in_ld ? rd_data : '0;
      o_dds_start     <= (state == ST_START);

      // A commit arriving in START is folded straight into the restart decision
      if (state == ST_START)
        pending <= 1'b0;
      else if (state != ST_IDLE && i_commit)
        pending <= 1'b1;

      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (i_commit) state <= ST_LD_THETA;
        end
        ST_LD_THETA, ST_LD_DELTA, ST_LD_AMPL: begin
          if (cnt == CH_W'(N_CH - 1)) begin
            cnt <= '0;
            case (state)
              ST_LD_THETA: state <= ST_LD_DELTA;
              ST_LD_DELTA: state <= ST_LD_AMPL;
              default:     state <= ST_START;
            endcase
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_START: state <= (pending || i_commit) ? ST_LD_THETA : ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dds_loader.sv
// Directed self-checking bench for dds_loader with a small shadow model.
module tb_dds_loader;

  localparam int SW = 16;
  localparam int NC = 8;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_commit = 1'b0;
  logic          o_busy;
  logic          o_dds_wr;
  logic [1:0]    o_dds_addrs;
  logic [SW-1:0] o_dds_fifo_data;
  logic          o_dds_start;

  dds_loader_if #(.SIG_WIDTH(SW), .N_CH(NC)) cfg_bus ();

  dds_loader #(.SIG_WIDTH(SW), .N_CH(NC)) dut (
    .clk             (clk),
    .i_rst           (i_rst),
    .cfg             (cfg_bus.slave),
    .i_commit        (i_commit),
    .o_busy          (o_busy),
    .o_dds_wr        (o_dds_wr),
    .o_dds_addrs     (o_dds_addrs),
    .o_dds_fifo_data (o_dds_fifo_data),
    .o_dds_start     (o_dds_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int        cyc;
    logic [1:0] a;
    logic [15:0] d;
  } word_t;

  int          cyc = 0;
  word_t       words[$];
  int          starts[$];
  logic [15:0] model [0:2][0:NC-1];
  int          n_checks = 0;
  int          n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(negedge clk);
      if (o_dds_wr) words.push_back('{cyc: cyc, a: o_dds_addrs, d: o_dds_fifo_data});
      if (o_dds_start) starts.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int b = 0; b < 3; b++)
      for (int c = 0; c < NC; c++)
        model[b][c] = 16'h0;
  endtask

  task automatic cfg_write(input logic [1:0] sel, input int ch, input logic [15:0] data);
    cfg_bus.i_cfg_valid = 1'b1;
    cfg_bus.i_cfg_sel   = sel;
    cfg_bus.i_cfg_ch    = ch[2:0];
    cfg_bus.i_cfg_data  = data;
    if (sel != 2'd3) model[sel][ch] = data;
    @(negedge clk);
    cfg_bus.i_cfg_valid = 1'b0;
  endtask

  task automatic do_commit(output int cc);
    cc = cyc + 1;
    i_commit = 1'b1;
    @(negedge clk);
    i_commit = 1'b0;
  endtask

  task automatic wait_starts(input string tag, input int n, input int budget);
    int k = 0;
    while (starts.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, starts.size(), n);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  o_busy, 0);
    check({tag, "_ready"}, cfg_bus.o_cfg_ready, 1);
    check({tag, "_err"},   cfg_bus.o_cfg_err, 0);
    check({tag, "_wr"},    o_dds_wr, 0);
    check({tag, "_addrs"}, o_dds_addrs, 3);
    check({tag, "_data"},  o_dds_fifo_data, 0);
    check({tag, "_start"}, o_dds_start, 0);
  endtask

  task automatic check_stream(input string tag, input int cc, input int base, input int sidx);
    if (words.size() < base + 3 * NC || starts.size() <= sidx) begin
      check({tag, "_len"}, words.size(), base + 3 * NC);
      return;
    end
    for (int b = 0; b < 3; b++)
      for (int c = 0; c < NC; c++) begin
        word_t w = words[base + b * NC + c];
        check($sformatf("%s_d%0d_%0d", tag, b, c), w.d, model[b][c]);
        check($sformatf("%s_a%0d_%0d", tag, b, c), w.a, b);
        check($sformatf("%s_t%0d_%0d", tag, b, c), w.cyc, cc + 1 + b * NC + c);
      end
    check({tag, "_start_lat"}, starts[sidx] - cc, 3 * NC + 1);
  endtask

  initial begin
    int cc;
    int cc2;
    cfg_bus.i_cfg_valid = 1'b0;
    cfg_bus.i_cfg_sel   = 2'd0;
    cfg_bus.i_cfg_ch    = '0;
    cfg_bus.i_cfg_data  = '0;
    clear_model();

    // reset and idle
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    i_rst = 1'b0;
    words.delete(); starts.delete();
    repeat (10) @(negedge clk);
    check_reset_outputs("idle");
    check("idle_words", words.size(), 0);
    check("idle_starts", starts.size(), 0);

    // basic ordered load
    for (int c = 0; c < NC; c++) begin
      cfg_write(2'd0, c, 16'h100 + 16'(c));
      cfg_write(2'd1, c, 16'h200 + 16'(c));
      cfg_write(2'd2, c, 16'h300 + 16'(c));
    end
    do_commit(cc);
    wait_starts("basic_start", 1, 40);
    check_stream("basic", cc, 0, 0);
    @(negedge clk);
    check("basic_ready_back", cfg_bus.o_cfg_ready, 1);
    check("basic_first", words[0].d, 16'h100);
    check("basic_last", words[23].d, 16'h307);

    // commit during an active load
    words.delete(); starts.delete();
    repeat (2) @(negedge clk);
    do_commit(cc);
    while (cyc < cc + 4) @(negedge clk);
    check("pend_ready", cfg_bus.o_cfg_ready, 0);
    do_commit(cc2);
    check("pend_busy", o_busy, 1);
    wait_starts("pend_starts", 2, 80);
    check_stream("pend1", cc, 0, 0);
    if (starts.size() > 0) check_stream("pend2", starts[0], 3 * NC, 1);
    repeat (5) @(negedge clk);
    check("pend_total_starts", starts.size(), 2);
    check("pend_idle", o_busy, 0);

    // illegal select
    words.delete(); starts.delete();
    cfg_write(2'd3, 2, 16'hBEEF);
    check("err_pulse", cfg_bus.o_cfg_err, 1);
    @(negedge clk);
    check("err_single", cfg_bus.o_cfg_err, 0);
    do_commit(cc);
    wait_starts("err_start", 1, 40);
    check_stream("err", cc, 0, 0);

    // same-cycle write and commit
    words.delete(); starts.delete();
    repeat (2) @(negedge clk);
    cc = cyc + 1;
    cfg_bus.i_cfg_valid = 1'b1;
    cfg_bus.i_cfg_sel   = 2'd0;
    cfg_bus.i_cfg_ch    = 3'd0;
    cfg_bus.i_cfg_data  = 16'hAAAA;
    model[0][0] = 16'hAAAA;
    i_commit = 1'b1;
    @(negedge clk);
    cfg_bus.i_cfg_valid = 1'b0;
    i_commit = 1'b0;
    wait_starts("same_start", 1, 40);
    check_stream("same", cc, 0, 0);
    if (words.size() > 0) check("same_first", words[0].d, 16'hAAAA);

    // reset in the middle of a load
    words.delete(); starts.delete();
    repeat (2) @(negedge clk);
    do_commit(cc);
    while (cyc < cc + 9) @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    i_rst = 1'b0;
    clear_model();
    repeat (40) @(negedge clk);
    check("midrst_no_start", starts.size(), 0);
    words.delete(); starts.delete();
    do_commit(cc);
    wait_starts("zero_start", 1, 40);
    check_stream("zero", cc, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/dds_loader.md
# dds_loader

Host-side writer for the DDS parameter shift registers. Holds a shadow copy of theta, delta and amplitude words for every DDS channel, accepts random-access host writes, and on commit streams all words into the DDS FIFO load port in a fixed order, then pulses the DDS start input. Sits between the AXI register slice and `dds`, driving its `i_dds_addrs` / `i_dds_fifo_data` / `i_dds_start` inputs.

## Interface
- `SIG_WIDTH`, 16: width of every parameter word and of the DDS data bus.
- `N_CH`, 8: number of DDS channels, equal to the DDS shift-register depth; power of two, ≥2.
- `CH_W`, `$clog2(N_CH)`: channel index width (derived, not overridden).

Ports:
- `clk` in 1: single clock for the block.
- `i_rst` in 1: reset, synchronous and active-high.
- `i_cfg_valid` in 1: host write request.
- `o_cfg_ready` out 1: write accepted when `i_cfg_valid && o_cfg_ready`.
- `i_cfg_sel` in 2: target bank: 0 theta, 1 delta, 2 ampl, 3 illegal.
- `i_cfg_ch` in CH_W: channel index.
- `i_cfg_data` in SIG_WIDTH: parameter word.
- `o_cfg_err` out 1: one-cycle pulse when an accepted write has sel=3.
- `i_commit` in 1: single-cycle request to load the DDS.
- `o_busy` out 1: load sequence in progress.
- `o_dds_wr` out 1: a valid word is on the DDS bus this cycle.
- `o_dds_addrs` out 2: FIFO select: 0 thetas, 1 deltas, 2 ampls, 3 none.
- `o_dds_fifo_data` out SIG_WIDTH: word being shifted in.
- `o_dds_start` out 1: one-cycle start pulse to the DDS.

## Operation
- Shadow file: 3 banks × N_CH words, all cleared by reset. An accepted write with sel 0–2 updates `bank[sel][ch]` at the clock edge. A write with sel=3 is accepted, discarded, and raises `o_cfg_err` on the next cycle.
- `o_cfg_ready = !o_busy`. Writes are back-pressured for the whole load sequence, so the shadow is stable while streaming.
- FSM states: IDLE → LD_THETA → LD_DELTA → LD_AMPL → START → IDLE.
  - IDLE: a sampled `i_commit` moves the FSM to LD_THETA. The channel counter is cleared.
  - LD_x: each cycle drives `bank[x][cnt]` with `o_dds_addrs=x` and `o_dds_wr=1`, then increments `cnt`. Channel order is ascending 0..N_CH-1, so channel 0 reaches the shift-register output first. At `cnt==N_CH-1` the counter wraps to 0 and the FSM advances to the next state.
  - START: `o_dds_start=1`, `o_dds_wr=0`, `o_dds_addrs=3`. Next state is IDLE, or LD_THETA if a commit is pending.
- Pending commit: `i_commit` sampled while busy sets a pending flag. Multiple commits collapse into one flag. The flag is consumed at START, and the reload begins with no IDLE cycle in between.
- Simultaneous write and commit in IDLE: the write lands first. The stream reflects the new value.
- Outside LD states: `o_dds_addrs=3`, `o_dds_fifo_data=0`, `o_dds_wr=0`. No DDS FIFO shifts.
- All outputs are registered.

## Timing
- Reset values:
  - `o_busy=0`, `o_cfg_ready=1`, `o_cfg_err=0`.
  - `o_dds_wr=0`, `o_dds_addrs=3`, `o_dds_fifo_data=0`, `o_dds_start=0`.
  - FSM in IDLE, counter 0, pending flag 0, shadow all zero.
- Commit sampled at edge 0:
  - The first theta word is valid in cycle 1.
  - Theta words occupy cycles 1..N_CH, delta words N_CH+1..2N_CH, amplitude words 2N_CH+1..3N_CH.
  - `o_dds_start` is high in cycle 3N_CH+1.
  - `o_busy` is high in cycles 1..3N_CH+1.
  - `o_cfg_ready` returns to 1 in cycle 3N_CH+2.
- Commit→start latency is 3·N_CH+1 cycles. With N_CH=8 that is 25.
- Reset asserted mid-sequence aborts immediately. No start pulse follows, the pending flag is cleared, and the shadow is zeroed.
- `o_cfg_err` is high exactly one cycle per illegal write.

## Structure
- Shared package `dds_pkg`:
  - Address constants THETAS=0, DELTAS=1, AMPLS=2, NONE=3, shared with `dds`.
  - FSM state enum `dds_ld_state_t`.
- Sub-module `dds_cfg_regfile`:
  - 3×N_CH shadow storage with one write port and one combinational read port (bank, channel).
  - Synchronous clear on `i_rst`.
- Top level contains the FSM, the channel counter, the pending flag and the output registers.

## Test plan
- Reset then idle for 10 cycles → `o_dds_addrs=3`, `o_dds_wr=0`, `o_cfg_ready=1`, no start pulse.
- N_CH=8. Write `theta[c]=0x100+c`, `delta[c]=0x200+c`, `ampl[c]=0x300+c`, then commit. Expect 24 words in order 0x100..0x107, 0x200..0x207, 0x300..0x307, each with the matching address, followed by a start pulse exactly 25 cycles after commit.
- Commit at cycle 5 of an active load → `o_cfg_ready` stays 0. A second 24-word stream begins the cycle after the first start pulse, and two start pulses are seen in total.
- Write with sel=3, ch=2, data 0xBEEF → `o_cfg_err` pulses once and all shadow words are unchanged (checked via a subsequent commit stream).
- Same-cycle write `theta[0]=0xAAAA` and commit → the first streamed word is 0xAAAA.
- Assert `i_rst` in cycle 10 of a load → all outputs return to reset values the next cycle, no start pulse occurs, and a subsequent commit streams all zeros.
